// File: rtl/wb_data_split.sv
// Splits one 32-bit Wishbone master access into a sequence of 8-bit classic
// slave cycles, one per selected byte lane, highest lane (offset 0) first.
module wb_data_split #(
    parameter int aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t        state_q;
    logic [aw-1:0] adr_q;
    logic [31:0]   dat_q;
    logic [31:0]   rdat_q;
    logic [3:0]    pend_q;
    logic          we_q;
    logic [aw-1:0] wbs_adr_q;
    logic [7:0]    wbs_dat_q;
    logic          wbs_we_q, wbs_cyc_q, wbs_stb_q;
    logic          ack_q, err_q, rty_q;

    logic [1:0]    cur_lane, nxt_lane, first_lane;
    logic [3:0]    pend_d;

    // Lane 3 carries byte offset 0, so the offset of a lane is its bitwise inverse.
    function automatic logic [1:0] top_lane(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] l);
        return d[{l, 3'b000} +: 8];
    endfunction

    always_comb begin
        cur_lane   = top_lane(pend_q);
        pend_d     = pend_q & ~(4'b0001 << cur_lane);
        nxt_lane   = top_lane(pend_d);
        first_lane = top_lane(wbm_sel_i);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            rdat_q    <= '0;
            pend_q    <= '0;
            we_q      <= 1'b0;
            wbs_adr_q <= '0;
            wbs_dat_q <= '0;
            wbs_we_q  <= 1'b0;
            wbs_cyc_q <= 1'b0;
            wbs_stb_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        adr_q  <= wbm_adr_i;
                        dat_q  <= wbm_dat_i;
                        pend_q <= wbm_sel_i;
                        we_q   <= wbm_we_i;
                        rdat_q <= '0;
                        if (wbm_sel_i != 4'b0000) begin
                            state_q   <= XFER;
                            wbs_cyc_q <= 1'b1;
                            wbs_stb_q <= 1'b1;
                            wbs_we_q  <= wbm_we_i;
                            wbs_adr_q <= {wbm_adr_i[aw-1:2], ~first_lane};
                            wbs_dat_q <= lane_byte(wbm_dat_i, first_lane);
                        end else begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (!wbm_cyc_i) begin
                        // Master abandoned the cycle: quietly discard the rest.
                        state_q   <= IDLE;
                        pend_q    <= '0;
                        wbs_cyc_q <= 1'b0;
                        wbs_stb_q <= 1'b0;
                        wbs_we_q  <= 1'b0;
                    end else if (wbs_err_i || wbs_rty_i) begin
                        state_q   <= RESP;
                        pend_q    <= '0;
                        wbs_cyc_q <= 1'b0;
                        wbs_stb_q <= 1'b0;
                        wbs_we_q  <= 1'b0;
                        err_q     <= wbs_err_i;
                        rty_q     <= !wbs_err_i;
                    end else if (wbs_ack_i) begin
                        if (!we_q)
                            rdat_q[{cur_lane, 3'b000} +: 8] <= wbs_dat_i;
                        pend_q <= pend_d;
                        if (pend_d != 4'b0000) begin
                            wbs_adr_q <= {adr_q[aw-1:2], ~nxt_lane};
                            wbs_dat_q <= lane_byte(dat_q, nxt_lane);
                        end else begin
                            state_q   <= RESP;
                            wbs_cyc_q <= 1'b0;
                            wbs_stb_q <= 1'b0;
                            wbs_we_q  <= 1'b0;
                            ack_q     <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rty_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Master burst hints and the word-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

    assign wbm_dat_o = rdat_q;
    assign wbm_ack_o = ack_q;
    assign wbm_err_o = err_q;
    assign wbm_rty_o = rty_q;
    assign wbs_adr_o = wbs_adr_q;
    assign wbs_dat_o = wbs_dat_q;
    assign wbs_we_o  = wbs_we_q;
    assign wbs_cyc_o = wbs_cyc_q;
    assign wbs_stb_o = wbs_stb_q;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;
endmodule
